// File: rtl/csr_trap_unit_if.sv
// Pipeline-side bundle for csr_trap_unit: CSR access port, interrupt lines,
// writeback observation and fetch-redirect outputs.
interface csr_trap_unit_if #(
    parameter int XLEN = 32,
    parameter int NIRQ = 4
);
    logic            i_csr_ren;
    logic [11:0]     i_csr_ridx;
    logic [XLEN-1:0] o_csr_rdata;
    logic            i_csr_wen;
    logic [11:0]     i_csr_widx;
    logic [XLEN-1:0] i_csr_wdata;
    logic [NIRQ-1:0] i_irq_ext;
    logic            i_irq_timer;
    logic            i_wb_valid;
    logic [XLEN-1:0] i_wb_pc;
    logic            i_mret;
    logic            o_stall;
    logic            o_redirect;
    logic [XLEN-1:0] o_redirect_pc;

    modport master (
        output i_csr_ren, i_csr_ridx, i_csr_wen, i_csr_widx, i_csr_wdata,
               i_irq_ext, i_irq_timer, i_wb_valid, i_wb_pc, i_mret,
        input  o_csr_rdata, o_stall, o_redirect, o_redirect_pc
    );

    modport slave (
        input  i_csr_ren, i_csr_ridx, i_csr_wen, i_csr_widx, i_csr_wdata,
               i_irq_ext, i_irq_timer, i_wb_valid, i_wb_pc, i_mret,
        output o_csr_rdata, o_stall, o_redirect, o_redirect_pc
    );
endinterface

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file with interrupt trap/mret sequencing beside writeback.
// Define CSR_COUNTER_EN to add 64-bit mcycle/minstret counters.
module csr_trap_unit #(
    parameter int XLEN = 32,
    parameter int NIRQ = 4
) (
    input logic            i_clk,
    input logic            i_rstn,
    csr_trap_unit_if.slave bus
);
    typedef enum logic {IDLE, PEND} state_t;

    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MIP      = 12'h344;
    localparam logic [XLEN-1:0] MIE_MASK =
        XLEN'(((((64'd1 << NIRQ) - 64'd1) << 16)) | 64'h888);

    state_t          state_q, state_d;
    logic            mstatus_mie_q, mstatus_mpie_q, msip_q;
    logic [XLEN-1:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q;
    logic [4:0]      cause_q, code_w;
    logic            redirect_q;
    logic [XLEN-1:0] redirect_pc_q;
    logic [XLEN-1:0] mip_w, pend_w, tvec_base, trap_pc;
    logic            pend_any, mret_fire, trap_fire;

    always_comb begin
        mip_w              = '0;
        mip_w[3]           = msip_q;
        mip_w[7]           = bus.i_irq_timer;
        mip_w[11]          = |bus.i_irq_ext;
        mip_w[16 +: NIRQ]  = bus.i_irq_ext;
    end

    assign pend_w   = mip_w & mie_q & {XLEN{mstatus_mie_q}};
    assign pend_any = |pend_w;

    // Lowest-priority sources are assigned first so later matches override them.
    always_comb begin
        code_w = 5'd0;
        if (pend_w[7])  code_w = 5'd7;
        if (pend_w[3])  code_w = 5'd3;
        if (pend_w[11]) code_w = 5'd11;
        for (int unsigned i = NIRQ; i > 0; i--) begin
            if (pend_w[16 + i - 1]) code_w = 5'(16 + i - 1);
        end
    end

    assign mret_fire = bus.i_wb_valid && bus.i_mret && (state_q != PEND);
    assign trap_fire = bus.i_wb_valid && (state_q == PEND);
    assign tvec_base = {mtvec_q[XLEN-1:2], 2'b00};
    assign trap_pc   = (mtvec_q[1:0] == 2'b01) ? tvec_base + (XLEN'(cause_q) << 2) : tvec_base;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pend_any && !mret_fire) state_d = PEND;
            PEND:    if (bus.i_wb_valid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.o_stall       = (state_q == PEND);
        bus.o_redirect    = redirect_q;
        bus.o_redirect_pc = redirect_pc_q;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            msip_q         <= 1'b0;
            mie_q          <= '0;
            mtvec_q        <= '0;
            mscratch_q     <= '0;
            mepc_q         <= '0;
            mcause_q       <= '0;
            cause_q        <= '0;
            redirect_q     <= 1'b0;
            redirect_pc_q  <= '0;
        end else begin
            redirect_q <= trap_fire || mret_fire;
            if (trap_fire)      redirect_pc_q <= trap_pc;
            else if (mret_fire) redirect_pc_q <= mepc_q;
            if (state_q == IDLE && state_d == PEND) cause_q <= code_w;

            // Trap/mret own mstatus/mepc/mcause on their edge; software writes there are dropped.
            if (trap_fire) begin
                mepc_q         <= {bus.i_wb_pc[XLEN-1:2], 2'b00};
                mcause_q       <= {1'b1, {(XLEN-6){1'b0}}, cause_q};
                mstatus_mpie_q <= mstatus_mie_q;
                mstatus_mie_q  <= 1'b0;
            end else if (mret_fire) begin
                mstatus_mie_q  <= mstatus_mpie_q;
                mstatus_mpie_q <= 1'b1;
            end else if (bus.i_csr_wen) begin
                case (bus.i_csr_widx)
                    A_MSTATUS: begin
                        mstatus_mie_q  <= bus.i_csr_wdata[3];
                        mstatus_mpie_q <= bus.i_csr_wdata[7];
                    end
                    A_MEPC:   mepc_q   <= {bus.i_csr_wdata[XLEN-1:2], 2'b00};
                    A_MCAUSE: mcause_q <= bus.i_csr_wdata;
                    default: ;
                endcase
            end

            if (bus.i_csr_wen) begin
                case (bus.i_csr_widx)
                    A_MIE:      mie_q      <= bus.i_csr_wdata & MIE_MASK;
                    A_MTVEC:    mtvec_q    <= bus.i_csr_wdata;
                    A_MSCRATCH: mscratch_q <= bus.i_csr_wdata;
                    A_MIP:      msip_q     <= bus.i_csr_wdata[3];
                    default: ;
                endcase
            end
        end
    end

`ifdef CSR_COUNTER_EN
    logic [63:0] mcycle_q, minstret_q;

    // Increment first, then let a half-write override just that half.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            mcycle_q <= mcycle_q + 64'd1;
            if (bus.i_wb_valid && state_q != PEND) minstret_q <= minstret_q + 64'd1;
            if (bus.i_csr_wen) begin
                case (bus.i_csr_widx)
                    12'hB00: mcycle_q[31:0]    <= bus.i_csr_wdata[31:0];
                    12'hB80: mcycle_q[63:32]   <= bus.i_csr_wdata[31:0];
                    12'hB02: minstret_q[31:0]  <= bus.i_csr_wdata[31:0];
                    12'hB82: minstret_q[63:32] <= bus.i_csr_wdata[31:0];
                    default: ;
                endcase
            end
        end
    end
`endif

    always_comb begin
        bus.o_csr_rdata = '0;
        if (bus.i_csr_ren) begin
            case (bus.i_csr_ridx)
                A_MSTATUS: begin
                    bus.o_csr_rdata[3]     = mstatus_mie_q;
                    bus.o_csr_rdata[7]     = mstatus_mpie_q;
                    bus.o_csr_rdata[12:11] = 2'b11;
                end
                A_MIE:      bus.o_csr_rdata = mie_q;
                A_MTVEC:    bus.o_csr_rdata = mtvec_q;
                A_MSCRATCH: bus.o_csr_rdata = mscratch_q;
                A_MEPC:     bus.o_csr_rdata = mepc_q;
                A_MCAUSE:   bus.o_csr_rdata = mcause_q;
                A_MIP:      bus.o_csr_rdata = mip_w;
`ifdef CSR_COUNTER_EN
                12'hB00:    bus.o_csr_rdata = XLEN'(mcycle_q[31:0]);
                12'hB80:    bus.o_csr_rdata = XLEN'(mcycle_q[63:32]);
                12'hB02:    bus.o_csr_rdata = XLEN'(minstret_q[31:0]);
                12'hB82:    bus.o_csr_rdata = XLEN'(minstret_q[63:32]);
`endif
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_csr_trap_unit.sv
// Bench for csr_trap_unit: behavioural CSR/trap model checked every cycle,
// plus directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_csr_trap_unit;
    localparam int XLEN = 32;
    localparam int NIRQ = 4;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    csr_trap_unit_if #(.XLEN(XLEN), .NIRQ(NIRQ)) bus ();
    csr_trap_unit #(.XLEN(XLEN), .NIRQ(NIRQ)) dut (.i_clk(clk), .i_rstn(rstn), .bus(bus));

    int checks = 0;
    int errors = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural model: CSR values plus "a trap is pending with this code".
    logic        m_mie = 0, m_mpie = 0, m_msip = 0, m_pend = 0, m_redir = 0;
    logic [31:0] m_mie_reg = 0, m_mtvec = 0, m_mscratch = 0, m_mepc = 0, m_mcause = 0;
    logic [31:0] m_redir_pc = 0;
    int unsigned m_code = 0;
    logic [63:0] m_cycle = 0, m_instret = 0;

    function automatic int unsigned top_cause();
        if (!m_mie) return 0;
        for (int i = 0; i < NIRQ; i++)
            if (bus.i_irq_ext[i] && m_mie_reg[16+i]) return 16 + i;
        if ((|bus.i_irq_ext) && m_mie_reg[11]) return 11;
        if (m_msip && m_mie_reg[3]) return 3;
        if (bus.i_irq_timer && m_mie_reg[7]) return 7;
        return 0;
    endfunction

    function automatic logic [31:0] mread(logic [11:0] idx);
        case (idx)
            12'h300: return 32'h1800 | (32'(m_mie) << 3) | (32'(m_mpie) << 7);
            12'h304: return m_mie_reg;
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h344: return (32'(m_msip) << 3) | (32'(bus.i_irq_timer) << 7) |
                            (32'(|bus.i_irq_ext) << 11) | (32'(bus.i_irq_ext) << 16);
`ifdef CSR_COUNTER_EN
            12'hB00: return m_cycle[31:0];
            12'hB80: return m_cycle[63:32];
            12'hB02: return m_instret[31:0];
            12'hB82: return m_instret[63:32];
`endif
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_mie = 0; m_mpie = 0; m_msip = 0; m_pend = 0; m_redir = 0;
            m_mie_reg = 0; m_mtvec = 0; m_mscratch = 0; m_mepc = 0; m_mcause = 0;
            m_redir_pc = 0; m_code = 0; m_cycle = 0; m_instret = 0;
        end else begin
            logic        trap, mret, pend_old;
            int unsigned c;
            logic [31:0] wd, base;
            pend_old = m_pend;
            trap = pend_old && bus.i_wb_valid;
            mret = !pend_old && bus.i_wb_valid && bus.i_mret;
            c    = top_cause();
            wd   = bus.i_csr_wdata;

            m_cycle = m_cycle + 1;
            if (bus.i_wb_valid && !pend_old) m_instret = m_instret + 1;
`ifdef CSR_COUNTER_EN
            if (bus.i_csr_wen) begin
                case (bus.i_csr_widx)
                    12'hB00: m_cycle[31:0]    = wd;
                    12'hB80: m_cycle[63:32]   = wd;
                    12'hB02: m_instret[31:0]  = wd;
                    12'hB82: m_instret[63:32] = wd;
                    default: ;
                endcase
            end
`endif
            m_redir = trap || mret;
            if (trap) begin
                base       = m_mtvec & ~32'h3;
                m_redir_pc = (m_mtvec[1:0] == 2'b01) ? base + 4 * m_code : base;
                m_mepc     = bus.i_wb_pc & ~32'h3;
                m_mcause   = 32'h8000_0000 | m_code;
                m_mpie     = m_mie;
                m_mie      = 0;
                m_pend     = 0;
            end else if (mret) begin
                m_redir_pc = m_mepc;
                m_mie      = m_mpie;
                m_mpie     = 1;
            end else if (bus.i_csr_wen) begin
                case (bus.i_csr_widx)
                    12'h300: begin m_mie = wd[3]; m_mpie = wd[7]; end
                    12'h341: m_mepc = wd & ~32'h3;
                    12'h342: m_mcause = wd;
                    default: ;
                endcase
            end
            if (bus.i_csr_wen) begin
                case (bus.i_csr_widx)
                    12'h304: m_mie_reg = wd & (32'h888 | (((32'd1 << NIRQ) - 1) << 16));
                    12'h305: m_mtvec = wd;
                    12'h340: m_mscratch = wd;
                    12'h344: m_msip = wd[3];
                    default: ;
                endcase
            end
            if (!pend_old && !mret && c != 0) begin
                m_pend = 1;
                m_code = c;
            end
        end
    end

    always @(negedge clk) begin
        check("stall", 32'(bus.o_stall), 32'(m_pend));
        check("redirect", 32'(bus.o_redirect), 32'(m_redir));
        if (m_redir) check("redirect_pc", bus.o_redirect_pc, m_redir_pc);
        check("rdata", bus.o_csr_rdata, bus.i_csr_ren ? mread(bus.i_csr_ridx) : 32'h0);
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(logic [11:0] idx, logic [31:0] data);
        bus.i_csr_wen = 1; bus.i_csr_widx = idx; bus.i_csr_wdata = data;
        step();
        bus.i_csr_wen = 0;
    endtask

    task automatic rd_chk(string name, logic [11:0] idx, logic [31:0] exp);
        bus.i_csr_ren = 1; bus.i_csr_ridx = idx;
        #3;
        check(name, bus.o_csr_rdata, exp);
        step();
        bus.i_csr_ren = 0;
    endtask

    task automatic wait_stall(string name);
        int n = 0;
        while (!bus.o_stall && n < 6) begin
            step();
            n++;
        end
        check(name, 32'(bus.o_stall), 32'd1);
    endtask

    task automatic wb(logic [31:0] pc, logic is_mret);
        bus.i_wb_valid = 1; bus.i_wb_pc = pc; bus.i_mret = is_mret;
        step();
        bus.i_wb_valid = 0; bus.i_mret = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rstn = 1;
        bus.i_csr_ren = 0; bus.i_csr_ridx = 0; bus.i_csr_wen = 0; bus.i_csr_widx = 0;
        bus.i_csr_wdata = 0; bus.i_irq_ext = 0; bus.i_irq_timer = 0;
        bus.i_wb_valid = 0; bus.i_wb_pc = 0; bus.i_mret = 0;
        #1 rstn = 0;
        repeat (3) step();
        check("reset_stall", 32'(bus.o_stall), 32'd0);
        check("reset_redirect", 32'(bus.o_redirect), 32'd0);
        check("reset_redirect_pc", bus.o_redirect_pc, 32'd0);
        rstn = 1;
        step();

        // T1 reset values
        rd_chk("t1_mstatus", 12'h300, 32'h1800);
        rd_chk("t1_mtvec", 12'h305, 32'h0);
        rd_chk("t1_mepc", 12'h341, 32'h0);
        rd_chk("t1_mcause", 12'h342, 32'h0);
        rd_chk("t1_unmapped", 12'h123, 32'h0);

        // T2 direct timer interrupt
        wr(12'h305, 32'h100);
        wr(12'h304, 32'h80);
        wr(12'h300, 32'h8);
        bus.i_irq_timer = 1;
        step();
        check("t2_stall", 32'(bus.o_stall), 32'd1);
        wb(32'h2004, 0);
        check("t2_redirect", 32'(bus.o_redirect), 32'd1);
        check("t2_redirect_pc", bus.o_redirect_pc, 32'h100);
        check("t2_stall_clear", 32'(bus.o_stall), 32'd0);
        bus.i_irq_timer = 0;
        rd_chk("t2_mepc", 12'h341, 32'h2004);
        rd_chk("t2_mcause", 12'h342, 32'h8000_0007);
        rd_chk("t2_mstatus", 12'h300, 32'h1880);

        // T3 vectored custom line; mepc write on the trap edge is dropped
        wr(12'h305, 32'h201);
        wr(12'h304, 32'h2_0000);
        wr(12'h300, 32'h8);
        bus.i_irq_ext = 4'b0010;
        step();
        check("t3_stall", 32'(bus.o_stall), 32'd1);
        bus.i_csr_wen = 1; bus.i_csr_widx = 12'h341; bus.i_csr_wdata = 32'h7777_0000;
        wb(32'h4000, 0);
        bus.i_csr_wen = 0;
        check("t3_redirect_pc", bus.o_redirect_pc, 32'h244);
        bus.i_irq_ext = 0;
        rd_chk("t3_mcause", 12'h342, 32'h8000_0011);
        rd_chk("t3_mepc_dropped_write", 12'h341, 32'h4000);

        // T4 priority: custom line 0 beats MEI/MSI/MTI
        wr(12'h305, 32'h100);
        wr(12'h304, 32'h1_0888);
        wr(12'h344, 32'h8);
        bus.i_irq_ext = 4'b0001;
        bus.i_irq_timer = 1;
        rd_chk("t4_mip", 12'h344, 32'h0001_0888);
        wr(12'h300, 32'h8);
        wait_stall("t4_stall");
        wb(32'h6000, 0);
        check("t4_redirect_pc", bus.o_redirect_pc, 32'h100);
        bus.i_irq_ext = 0;
        bus.i_irq_timer = 0;
        rd_chk("t4_mcause", 12'h342, 32'h8000_0010);
        wr(12'h344, 32'h0);

        // T5 mret with timer becoming pending in the same cycle
        wr(12'h304, 32'h80);
        wr(12'h300, 32'h80);
        wr(12'h341, 32'h3000);
        bus.i_irq_timer = 1;
        wb(32'h2ffc, 1);
        check("t5_redirect", 32'(bus.o_redirect), 32'd1);
        check("t5_redirect_pc", bus.o_redirect_pc, 32'h3000);
        check("t5_no_stall_yet", 32'(bus.o_stall), 32'd0);
        rd_chk("t5_mstatus", 12'h300, 32'h1888);
        check("t5_stall", 32'(bus.o_stall), 32'd1);
        wb(32'h5008, 0);
        check("t5_trap_pc", bus.o_redirect_pc, 32'h100);
        bus.i_irq_timer = 0;
        rd_chk("t5_mcause", 12'h342, 32'h8000_0007);
        rd_chk("t5_mepc", 12'h341, 32'h5008);

        // Reset while a trap is pending
        wr(12'h300, 32'h8);
        bus.i_irq_timer = 1;
        wait_stall("rst_mid_stall");
        rstn = 0;
        #1;
        check("rst_mid_async_stall", 32'(bus.o_stall), 32'd0);
        check("rst_mid_async_redirect", 32'(bus.o_redirect), 32'd0);
        bus.i_irq_timer = 0;
        step();
        step();
        rstn = 1;
        step();
        rd_chk("rst_mid_mstatus", 12'h300, 32'h1800);
        rd_chk("rst_mid_mie", 12'h304, 32'h0);

        // T6 counters
`ifdef CSR_COUNTER_EN
        wr(12'hB80, 32'h0);
        wr(12'hB00, 32'hFFFF_FFFF);
        rd_chk("t6_mcycle_lo_max", 12'hB00, 32'hFFFF_FFFF);
        rd_chk("t6_mcycle_hi_carry", 12'hB80, 32'h1);
        rd_chk("t6_mcycle_lo_wrapped", 12'hB00, 32'h1);
        wr(12'hB02, 32'h5);
        bus.i_wb_valid = 1;
        repeat (3) step();
        bus.i_wb_valid = 0;
        rd_chk("t6_minstret", 12'hB02, 32'h8);
`else
        wr(12'hB00, 32'h1234);
        rd_chk("t6_mcycle_absent", 12'hB00, 32'h0);
        rd_chk("t6_minstret_absent", 12'hB02, 32'h0);
`endif
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
